// File: rtl/serial_adder.sv
// Bit-serial adder: operands shift LSB-first through a two-half-adder full-adder,
// one bit per clock, and the assembled sum plus carry-out are registered on completion.

module Half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_ha1_sum;
  logic             w_ha1_carry;
  logic             w_ha2_sum;
  logic             w_ha2_carry;
  logic             w_carry_nxt;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum_nxt;

  Half_adder u_ha1 (
    .a_i     (r_a_sr[0]),
    .b_i     (r_b_sr[0]),
    .sum_o   (w_ha1_sum),
    .carry_o (w_ha1_carry)
  );

  Half_adder u_ha2 (
    .a_i     (w_ha1_sum),
    .b_i     (r_carry),
    .sum_o   (w_ha2_sum),
    .carry_o (w_ha2_carry)
  );

  assign w_carry_nxt = w_ha1_carry | w_ha2_carry;
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  // A start is honoured in IDLE and in DONE, so back-to-back runs lose no cycle.
  assign w_accept    = start_i && (r_state != S_RUN);
  assign w_sum_nxt   = {w_ha2_sum, r_sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      sum_o    <= '0;
      carry_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (w_accept) begin
        r_a_sr   <= a_i;
        r_b_sr   <= b_i;
        r_sum_sr <= '0;
        r_carry  <= 1'b0;
        r_cnt    <= '0;
        busy_o   <= 1'b1;
        r_state  <= S_RUN;
      end else begin
        case (r_state)
          S_RUN: begin
            r_sum_sr <= w_sum_nxt;
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_carry  <= w_carry_nxt;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              sum_o   <= w_sum_nxt;
              carry_o <= w_carry_nxt;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
